// File: rtl/pad_window_scanner_if.sv
// rtl/pad_window_scanner_if.sv - window-centre beat stream between scanner and line-buffer/MAC datapath
interface pad_window_scanner_if #(
   parameter int W_BITS = 6,
   parameter int H_BITS = 6
);
   logic                       valid;
   logic                       ready;
   logic [H_BITS+W_BITS-1:0]   addr;
   logic [8:0]                 mask;
   logic                       last;

   modport master (
      output valid,
      output addr,
      output mask,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  addr,
      input  mask,
      input  last,
      output ready
   );
endinterface

// File: rtl/pad_window_scanner.sv
// rtl/pad_window_scanner.sv - raster 3x3 window-centre scanner with zero-pad masks
// Optional feature macro: PADSCAN_STRIDE2_EN (adds i_stride2 and per-frame stride-2 mode).
module pad_window_scanner #(
   parameter int W_BITS = 6,
   parameter int H_BITS = 6
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_clear,
`ifdef PADSCAN_STRIDE2_EN
   input  logic                    i_stride2,
`endif
   pad_window_scanner_if.master    m_if,
   output logic                    o_busy,
   output logic                    o_done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q;
   logic [H_BITS-1:0]   row_q;
   logic [W_BITS-1:0]   col_q;
   logic                valid_q;
   logic [8:0]          mask_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;
`ifdef PADSCAN_STRIDE2_EN
   logic                stride_q;
`endif

   logic [1:0]          step_start;
   logic [1:0]          step_cur;
   logic [W_BITS:0]     col_inc;
   logic [H_BITS:0]     row_inc;
   logic [W_BITS-1:0]   col_d;
   logic [H_BITS-1:0]   row_d;

   function automatic logic [8:0] mask_of(input logic [H_BITS-1:0] r, input logic [W_BITS-1:0] c);
      logic top, bot, lft, rgt;
      top = (r == '0);
      bot = (r == '1);
      lft = (c == '0);
      rgt = (c == '1);
      return {bot | rgt, bot, bot | lft, rgt, 1'b0, lft, top | rgt, top, top | lft};
   endfunction

   // Final centre sits exactly one step below the wrap point on both axes.
   function automatic logic last_of(input logic [H_BITS-1:0] r, input logic [W_BITS-1:0] c,
                                    input logic [1:0] s);
      logic [H_BITS:0] ri;
      logic [W_BITS:0] ci;
      ri = {1'b0, r} + {{(H_BITS-1){1'b0}}, s};
      ci = {1'b0, c} + {{(W_BITS-1){1'b0}}, s};
      return ri[H_BITS] & ci[W_BITS];
   endfunction

   always_comb begin
`ifdef PADSCAN_STRIDE2_EN
      step_start = i_stride2 ? 2'd2 : 2'd1;
      step_cur   = stride_q ? 2'd2 : 2'd1;
`else
      step_start = 2'd1;
      step_cur   = 2'd1;
`endif
      col_inc = {1'b0, col_q} + {{(W_BITS-1){1'b0}}, step_cur};
      row_inc = {1'b0, row_q} + {{(H_BITS-1){1'b0}}, step_cur};
      col_d   = col_inc[W_BITS] ? '0 : col_inc[W_BITS-1:0];
      row_d   = col_inc[W_BITS] ? row_inc[H_BITS-1:0] : row_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         row_q    <= '0;
         col_q    <= '0;
         valid_q  <= 1'b0;
         mask_q   <= '0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PADSCAN_STRIDE2_EN
         stride_q <= 1'b0;
`endif
      end else if (i_clear) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         valid_q <= 1'b0;
         mask_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (i_start) begin
                  state_q  <= RUN;
                  row_q    <= '0;
                  col_q    <= '0;
                  valid_q  <= 1'b1;
                  mask_q   <= mask_of('0, '0);
                  last_q   <= last_of('0, '0, step_start);
                  busy_q   <= 1'b1;
`ifdef PADSCAN_STRIDE2_EN
                  stride_q <= i_stride2;
`endif
               end
            end
            RUN: begin
               if (valid_q && m_if.ready) begin
                  if (last_q) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     row_q  <= row_d;
                     col_q  <= col_d;
                     mask_q <= mask_of(row_d, col_d);
                     last_q <= last_of(row_d, col_d, step_cur);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_if.valid = valid_q;
   assign m_if.addr  = {row_q, col_q};
   assign m_if.mask  = mask_q;
   assign m_if.last  = last_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_pad_window_scanner.sv
// tb/tb_pad_window_scanner.sv - directed bench: 4x4 instance and default 64x64 instance
module tb_pad_window_scanner;

   logic clk;
   logic rst_n;
   logic start_s, clear_s, stride_s;
   logic start_l, clear_l, stride_l;
   logic busy_s, done_s, busy_l, done_l;
   int   n_checks;
   int   n_err;

   pad_window_scanner_if #(.W_BITS(2), .H_BITS(2)) s_if ();
   pad_window_scanner_if #(.W_BITS(6), .H_BITS(6)) l_if ();

   pad_window_scanner #(.W_BITS(2), .H_BITS(2)) dut_s (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start_s),
      .i_clear   (clear_s),
`ifdef PADSCAN_STRIDE2_EN
      .i_stride2 (stride_s),
`endif
      .m_if      (s_if),
      .o_busy    (busy_s),
      .o_done    (done_s)
   );

   pad_window_scanner #(.W_BITS(6), .H_BITS(6)) dut_l (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start_l),
      .i_clear   (clear_l),
`ifdef PADSCAN_STRIDE2_EN
      .i_stride2 (stride_l),
`endif
      .m_if      (l_if),
      .o_busy    (busy_l),
      .o_done    (done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      rst_n = 1'b0;
      start_s = 0; clear_s = 0; stride_s = 0; s_if.ready = 0;
      start_l = 0; clear_l = 0; stride_l = 0; l_if.ready = 0;
      tick(); tick();
      chk("rst_valid", {31'd0, s_if.valid}, 32'd0);
      chk("rst_addr",  {28'd0, s_if.addr}, 32'd0);
      chk("rst_mask",  {23'd0, s_if.mask}, 32'd0);
      chk("rst_last",  {31'd0, s_if.last}, 32'd0);
      chk("rst_busy",  {31'd0, busy_s}, 32'd0);
      chk("rst_done",  {31'd0, done_s}, 32'd0);
      rst_n = 1'b1;
      tick();

      // stride 1, ready held high
      s_if.ready = 1; start_s = 1;
      tick();
      start_s = 0;
      for (int i = 0; i < 16; i++) begin
         chk("s1_valid", {31'd0, s_if.valid}, 32'd1);
         chk("s1_addr",  {28'd0, s_if.addr}, i);
         chk("s1_last",  {31'd0, s_if.last}, (i == 15) ? 32'd1 : 32'd0);
         chk("s1_busy",  {31'd0, busy_s}, 32'd1);
         if (i == 0)  chk("s1_mask0",  {23'd0, s_if.mask}, 32'h04F);
         if (i == 3)  chk("s1_mask3",  {23'd0, s_if.mask}, 32'h127);
         if (i == 5)  chk("s1_mask5",  {23'd0, s_if.mask}, 32'h000);
         if (i == 12) chk("s1_mask12", {23'd0, s_if.mask}, 32'h1C9);
         if (i == 15) chk("s1_mask15", {23'd0, s_if.mask}, 32'h1E4);
         tick();
      end
      chk("s1_done",       {31'd0, done_s}, 32'd1);
      chk("s1_done_valid", {31'd0, s_if.valid}, 32'd0);
      chk("s1_done_busy",  {31'd0, busy_s}, 32'd1);
      tick();
      chk("s1_idle_done",  {31'd0, done_s}, 32'd0);
      chk("s1_idle_busy",  {31'd0, busy_s}, 32'd0);

      // ready toggling: stall on even cycles, accept on odd
      start_s = 1;
      tick();
      start_s = 0;
      for (int c = 0; c < 32; c++) begin
         s_if.ready = c[0];
         chk("tg_valid", {31'd0, s_if.valid}, 32'd1);
         chk("tg_addr",  {28'd0, s_if.addr}, c / 2);
         chk("tg_last",  {31'd0, s_if.last}, (c / 2 == 15) ? 32'd1 : 32'd0);
         if (c / 2 == 3) chk("tg_mask3", {23'd0, s_if.mask}, 32'h127);
         tick();
      end
      chk("tg_done",  {31'd0, done_s}, 32'd1);
      chk("tg_valid_off", {31'd0, s_if.valid}, 32'd0);
      s_if.ready = 1;
      tick();

`ifdef PADSCAN_STRIDE2_EN
      begin
         logic [3:0]  st_addr [4];
         logic [8:0]  st_mask [4];
         st_addr = '{4'd0, 4'd2, 4'd8, 4'd10};
         st_mask = '{9'h04F, 9'h007, 9'h049, 9'h000};
         stride_s = 1; start_s = 1;
         tick();
         start_s = 0; stride_s = 0;
         for (int i = 0; i < 4; i++) begin
            chk("st_valid", {31'd0, s_if.valid}, 32'd1);
            chk("st_addr",  {28'd0, s_if.addr}, {28'd0, st_addr[i]});
            chk("st_mask",  {23'd0, s_if.mask}, {23'd0, st_mask[i]});
            chk("st_last",  {31'd0, s_if.last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
         end
         chk("st_done", {31'd0, done_s}, 32'd1);
         tick();
      end
`endif

      // abort with clear at beat 5
      start_s = 1;
      tick();
      start_s = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("cl_addr5", {28'd0, s_if.addr}, 32'd5);
      clear_s = 1; start_s = 1;
      tick();
      clear_s = 0; start_s = 0;
      chk("cl_valid", {31'd0, s_if.valid}, 32'd0);
      chk("cl_busy",  {31'd0, busy_s}, 32'd0);
      chk("cl_done",  {31'd0, done_s}, 32'd0);
      tick();
      chk("cl_done2", {31'd0, done_s}, 32'd0);
      start_s = 1;
      tick();
      start_s = 0;
      chk("cl_restart_valid", {31'd0, s_if.valid}, 32'd1);
      chk("cl_restart_addr",  {28'd0, s_if.addr}, 32'd0);

      // asynchronous reset mid-frame
      tick(); tick(); tick();
      chk("ar_addr_pre", {28'd0, s_if.addr}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, s_if.valid}, 32'd0);
      chk("ar_addr",  {28'd0, s_if.addr}, 32'd0);
      chk("ar_mask",  {23'd0, s_if.mask}, 32'd0);
      chk("ar_busy",  {31'd0, busy_s}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_idle_valid", {31'd0, s_if.valid}, 32'd0);
      start_s = 1;
      tick();
      start_s = 0;
      chk("ar_restart_addr", {28'd0, s_if.addr}, 32'd0);
      chk("ar_restart_mask", {23'd0, s_if.mask}, 32'h04F);
      clear_s = 1;
      tick();
      clear_s = 0;

      // default 64x64 frame
      l_if.ready = 1; start_l = 1;
      tick();
      start_l = 0;
      for (int i = 0; i < 4096; i++) begin
         start_l = (i == 100);
         chk("lg_addr",  {20'd0, l_if.addr}, i);
         chk("lg_valid", {31'd0, l_if.valid}, 32'd1);
         if (i == 63)   chk("lg_mask63",   {23'd0, l_if.mask}, 32'h127);
         if (i == 4032) chk("lg_mask4032", {23'd0, l_if.mask}, 32'h1C9);
         if (i == 102)  chk("lg_start_ignored", {20'd0, l_if.addr}, 32'd102);
         if (i == 4095 || i == 4094)
            chk("lg_last", {31'd0, l_if.last}, (i == 4095) ? 32'd1 : 32'd0);
         tick();
      end
      start_l = 0;
      chk("lg_done",  {31'd0, done_l}, 32'd1);
      chk("lg_valid_off", {31'd0, l_if.valid}, 32'd0);
      tick();
      chk("lg_busy_off", {31'd0, busy_l}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
